// File: rtl/chu_vga_multi_sprite_core.sv
// chu_vga_multi_sprite_core
//
// Purpose: overlays up to NS hardware sprites on a daisy-chained VGA pixel
// stream. Each sprite has a position, an enable bit and a base address into a
// shared pattern RAM. The lowest-indexed sprite covering the current pixel
// wins. Its pattern word replaces the upstream pixel unless the word equals
// KEY_COLOR. Sprite overlaps are collected per frame into a collision vector.
//
// Optional feature: define MSPRITE_HFLIP_EN to build horizontal mirroring,
// which is controlled by the per-sprite hflip bit. Without the macro, the
// hflip bit is ignored and no mirror logic exists.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   x, y       current pixel coordinate from the frame counter
//   cs, write  slot select / write strobe (a write needs both high)
//   addr       slot word address:
//                addr[13]=1 -> pattern RAM word addr[AW-1:0]
//                addr[13]=0 -> sprite addr[4:2], register addr[1:0]
//                              (0=x0, 1=y0, 2=ctrl)
//   wr_data    write data. The ctrl layout is:
//                en=[0], hflip=[1], base=[AW+15:16]
//   si_rgb     upstream pixel
//   so_rgb     downstream pixel (2-cycle latency from x/y/si_rgb)
//   collision  per-sprite overlap flags for the previous frame
module chu_vga_multi_sprite_core #(
  parameter int CD = 12,
  parameter int NS = 4,
  parameter int SW = 32,
  parameter int SH = 32,
  parameter int AW = 12,
  parameter logic [CD-1:0] KEY_COLOR = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb,
  output logic [NS-1:0] collision
);

  logic [10:0]   x0   [NS];
  logic [10:0]   y0   [NS];
  logic [AW-1:0] base [NS];
  logic [NS-1:0] en;
`ifdef MSPRITE_HFLIP_EN
  logic [NS-1:0] hflip;
  logic          win_flip;
`endif

  logic [CD-1:0] ram [2**AW];
  logic [CD-1:0] ram_q;

  logic [NS-1:0] hit;
  logic [NS-1:0] multi_hit;
  logic [NS-1:0] sticky;
  logic          any_hit;
  logic [10:0]   win_x0;
  logic [10:0]   win_y0;
  logic [AW-1:0] win_base;
  logic [10:0]   dx;
  logic [10:0]   dy;
  logic [10:0]   col;
  logic [AW-1:0] pat_addr;

  logic          s1_hit;
  logic [AW-1:0] s1_addr;
  logic [CD-1:0] s1_si;
  logic          s2_hit;
  logic [CD-1:0] s2_si;

  logic          unused_ok;

  // Only some of the address and data bits are decoded. This reduction marks
  // the remaining bits as intentionally ignored.
  assign unused_ok = ^{wr_data, addr};

  // Sprite register file. Writes to sprite slots >= NS match no loop index,
  // so those writes are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) begin
        x0[i]   <= '0;
        y0[i]   <= '0;
        base[i] <= '0;
      end
      en <= '0;
`ifdef MSPRITE_HFLIP_EN
      hflip <= '0;
`endif
    end else if (cs && write && !addr[13]) begin
      for (int i = 0; i < NS; i++) begin
        if (addr[4:2] == 3'(i)) begin
          case (addr[1:0])
            2'd0: x0[i] <= wr_data[10:0];
            2'd1: y0[i] <= wr_data[10:0];
            2'd2: begin
              en[i]   <= wr_data[0];
              base[i] <= wr_data[AW+15:16];
`ifdef MSPRITE_HFLIP_EN
              hflip[i] <= wr_data[1];
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Hit test. The compares are widened to 12 bits so that x0+SW near the
  // right edge cannot wrap back to a small value.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NS; i++) begin
      hit[i] = en[i]
            && ({1'b0, x} >= {1'b0, x0[i]})
            && ({1'b0, x} <  ({1'b0, x0[i]} + 12'(SW)))
            && ({1'b0, y} >= {1'b0, y0[i]})
            && ({1'b0, y} <  ({1'b0, y0[i]} + 12'(SH)));
    end
  end

  // Priority select. The loop scans downward, so the lowest-indexed hitting
  // sprite is assigned last and wins.
  always_comb begin
    any_hit  = 1'b0;
    win_x0   = '0;
    win_y0   = '0;
    win_base = '0;
`ifdef MSPRITE_HFLIP_EN
    win_flip = 1'b0;
`endif
    for (int i = NS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit  = 1'b1;
        win_x0   = x0[i];
        win_y0   = y0[i];
        win_base = base[i];
`ifdef MSPRITE_HFLIP_EN
        win_flip = hflip[i];
`endif
      end
    end
  end

  // Pattern address for the winner. The sum wraps modulo the RAM size.
  always_comb begin
    dx = x - win_x0;
    dy = y - win_y0;
`ifdef MSPRITE_HFLIP_EN
    col = win_flip ? (11'(SW - 1) - dx) : dx;
`else
    col = dx;
`endif
    pat_addr = win_base + AW'(32'(dy) * 32'(SW)) + AW'(col);
  end

  // A pixel covered by two or more sprites flags every sprite that covers it.
  assign multi_hit = ((hit & (hit - NS'(1))) != '0) ? hit : '0;

  // Two-stage pixel pipeline and per-frame collision capture. The collision
  // vector at (0,0) includes the hits at (0,0) itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_hit    <= 1'b0;
      s1_addr   <= '0;
      s1_si     <= '0;
      s2_hit    <= 1'b0;
      s2_si     <= '0;
      sticky    <= '0;
      collision <= '0;
    end else begin
      s1_hit  <= any_hit;
      s1_addr <= pat_addr;
      s1_si   <= si_rgb;
      s2_hit  <= s1_hit;
      s2_si   <= s1_si;
      if (x == 11'd0 && y == 11'd0) begin
        collision <= sticky | multi_hit;
        sticky    <= '0;
      end else begin
        sticky <= sticky | multi_hit;
      end
    end
  end

  // The pattern RAM is not reset. The read uses the value before any write in
  // the same cycle, so a same-address write returns the old data. Output
  // gating comes from the reset-cleared s2_hit, so stale ram_q never escapes.
  always_ff @(posedge clk) begin
    if (cs && write && addr[13]) begin
      ram[addr[AW-1:0]] <= wr_data[CD-1:0];
    end
    ram_q <= ram[s1_addr];
  end

  assign so_rgb = (s2_hit && (ram_q != KEY_COLOR)) ? ram_q : s2_si;

endmodule

// File: tb/tb_chu_vga_multi_sprite_core.sv
// tb_chu_vga_multi_sprite_core
//
// Purpose: self-checking bench for chu_vga_multi_sprite_core with the default
// parameters (CD=12, NS=4, SW=SH=32, AW=12, KEY_COLOR=0). A reference model
// holds the sprite settings and the pattern RAM as plain arrays. The model
// derives each expected pixel and collision vector from the sprite rules.
// Honors MSPRITE_HFLIP_EN in the same way as the design.
module tb_chu_vga_multi_sprite_core;

  logic        clk;
  logic        reset_n;
  logic [10:0] x;
  logic [10:0] y;
  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [11:0] si_rgb;
  logic [11:0] so_rgb;
  logic [3:0]  collision;

  int checks;
  int errors;

  int          m_x0   [4];
  int          m_y0   [4];
  int          m_base [4];
  bit          m_en   [4];
  bit          m_flip [4];
  logic [11:0] m_ram  [4096];
  logic [3:0]  m_sticky;
  logic [3:0]  m_coll;

  logic [11:0] prev_exp;
  bit          prev_valid;

  chu_vga_multi_sprite_core dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .x         (x),
    .y         (y),
    .cs        (cs),
    .write     (write),
    .addr      (addr),
    .wr_data   (wr_data),
    .si_rgb    (si_rgb),
    .so_rgb    (so_rgb),
    .collision (collision)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_hits(input int xx, input int yy);
    logic [3:0] h;
    h = '0;
    for (int i = 0; i < 4; i++) begin
      h[i] = m_en[i] && xx >= m_x0[i] && xx < m_x0[i] + 32
                     && yy >= m_y0[i] && yy < m_y0[i] + 32;
    end
    return h;
  endfunction

  function automatic logic [11:0] model_rgb(input int xx, input int yy, input logic [11:0] si);
    logic [3:0]  h;
    logic [11:0] res;
    bit          done;
    int          c;
    int          a;
    h    = model_hits(xx, yy);
    res  = si;
    done = 0;
    for (int i = 0; i < 4; i++) begin
      if (h[i] && !done) begin
        done = 1;
        c = xx - m_x0[i];
`ifdef MSPRITE_HFLIP_EN
        if (m_flip[i]) c = 31 - c;
`endif
        a = (m_base[i] + (yy - m_y0[i]) * 32 + c) % 4096;
        if (m_ram[a] != 12'h000) res = m_ram[a];
      end
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_x0[i] = 0; m_y0[i] = 0; m_base[i] = 0; m_en[i] = 0; m_flip[i] = 0;
    end
    m_sticky   = '0;
    m_coll     = '0;
    prev_valid = 0;
  endtask

  task automatic wr_raw(input logic [13:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    tick();
    cs = 1'b0; write = 1'b0;
    prev_valid = 0;
  endtask

  task automatic ram_write(input int a, input logic [11:0] v);
    wr_raw(14'h2000 | 14'(a), 32'(v));
    m_ram[a] = v;
  endtask

  task automatic set_sprite(input int i, input int sx, input int sy, input bit sen,
                            input bit sflip, input int sbase);
    wr_raw(14'(i * 4 + 0), 32'(sx));
    wr_raw(14'(i * 4 + 1), 32'(sy));
    wr_raw(14'(i * 4 + 2), {4'b0, 12'(sbase), 14'b0, sflip, sen});
    m_x0[i] = sx; m_y0[i] = sy; m_en[i] = sen; m_flip[i] = sflip; m_base[i] = sbase;
  endtask

  // Drives one pixel and advances one clock. After the clock edge, so_rgb
  // belongs to the pixel driven by the previous call. collision belongs to
  // this pixel.
  task automatic pixel(input int xx, input int yy, input logic [11:0] si, input string tag);
    logic [11:0] e;
    logic [3:0]  h;
    x = 11'(xx); y = 11'(yy); si_rgb = si;
    e = model_rgb(xx, yy, si);
    h = model_hits(xx, yy);
    if ($countones(h) >= 2) m_sticky |= h;
    if (xx == 0 && yy == 0) begin
      m_coll   = m_sticky;
      m_sticky = '0;
    end
    tick();
    if (prev_valid) check({tag, "_rgb"}, 32'(so_rgb), 32'(prev_exp));
    check({tag, "_coll"}, 32'(collision), 32'(m_coll));
    prev_exp   = e;
    prev_valid = 1;
  endtask

  task automatic park();
    pixel(2047, 2047, 12'h008, "park");
  endtask

  initial begin
    checks = 0; errors = 0;
    clk = 1'b0; reset_n = 1'b0;
    x = 11'd2047; y = 11'd2047;
    cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0; si_rgb = 12'h008;
    model_reset();

    // Reset state
    repeat (3) tick();
    check("rst_rgb", 32'(so_rgb), 32'h0);
    check("rst_coll", 32'(collision), 32'h0);
    reset_n = 1'b1;

    // Fill the whole pattern RAM. About a quarter of the words are key colour.
    for (int a = 0; a < 4096; a++) begin
      ram_write(a, ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095)));
    end

    // No sprites enabled: the stream passes through with 2-cycle delay
    pixel(5, 5, 12'h008, "pass0");
    pixel(300, 200, 12'h123, "pass1");
    pixel(640, 480, 12'h008, "pass2");
    park();

    // Single sprite at (100,50): hit corners and edges just outside
    ram_write(0, 12'hF00);
    ram_write(31, 12'h0F0);
    set_sprite(0, 100, 50, 1, 0, 0);
    pixel(100, 50, 12'h055, "s0_origin");
    pixel(131, 50, 12'h056, "s0_right");
    pixel(132, 50, 12'h066, "s0_out_x");
    pixel(99, 50, 12'h067, "s0_out_l");
    pixel(100, 81, 12'h068, "s0_bottom");
    pixel(100, 82, 12'h069, "s0_out_y");
    park();

    // cs without write must leave RAM unchanged
    cs = 1'b1; write = 1'b0; addr = 14'h2000; wr_data = 32'h777;
    tick();
    cs = 1'b0;
    prev_valid = 0;
    pixel(100, 50, 12'h011, "nowrite");
    park();

    // hflip bit: mirrors only when the feature is built
    set_sprite(0, 100, 50, 1, 1, 0);
    pixel(100, 50, 12'h012, "hflip");
    pixel(131, 50, 12'h013, "hflip_r");
    park();

    // Overlap at (10,10): a key-colour winner shows si_rgb, not sprite 1
    ram_write(1024, 12'h000);
    ram_write(2048, 12'hABC);
    set_sprite(0, 10, 10, 1, 0, 1024);
    set_sprite(1, 10, 10, 1, 0, 2048);
    pixel(10, 10, 12'h321, "keyhide");
    pixel(0, 0, 12'h322, "frame0");
    pixel(0, 0, 12'h323, "frame1");
    park();

    // Ignored writes: sprite slot 5 and register 3 of sprite 1
    set_sprite(1, 60, 10, 1, 0, 2048);
    wr_raw(14'd20, 32'd500);
    wr_raw(14'd21, 32'd500);
    wr_raw(14'd22, 32'h0000_0000);
    wr_raw(14'd7, 32'hFFFF_FFFF);
    pixel(60, 10, 12'h400, "ign_s1");
    pixel(10, 10, 12'h401, "ign_s0");
    park();

    // Randomized rounds: sprites and pixels, with occasional frame starts
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        set_sprite(i, $urandom_range(0, 150), $urandom_range(0, 100),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 4095));
      end
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 19) == 0)
          pixel(0, 0, 12'($urandom_range(0, 4095)), "rnd");
        else
          pixel($urandom_range(0, 200), $urandom_range(0, 140),
                12'($urandom_range(0, 4095)), "rnd");
      end
      park();
    end

    // Mid-sprite reset with overlapping sprites and a latched collision
    set_sprite(0, 100, 50, 1, 0, 0);
    set_sprite(1, 100, 50, 1, 0, 2048);
    set_sprite(2, 0, 0, 0, 0, 0);
    set_sprite(3, 0, 0, 0, 0, 0);
    pixel(100, 50, 12'h501, "pre_rst");
    pixel(0, 0, 12'h502, "pre_rst");
    pixel(101, 50, 12'h503, "pre_rst");
    pixel(102, 50, 12'h504, "pre_rst");
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_rgb", 32'(so_rgb), 32'h0);
    check("async_rst_coll", 32'(collision), 32'h0);
    model_reset();
    tick();
    check("in_rst_rgb", 32'(so_rgb), 32'h0);
    reset_n = 1'b1;
    pixel(100, 50, 12'h456, "post_rst");
    pixel(101, 50, 12'h457, "post_rst");
    park();
    set_sprite(0, 100, 50, 1, 0, 0);
    pixel(100, 50, 12'h458, "ram_kept");
    park();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
